// File: rtl/ctrl_unit_pipelined.sv
// ctrl_unit_pipelined: registered ID-stage decoder that also sequences
// load-use stall bubbles and branch-mispredict flush bubbles.
module ctrl_unit_pipelined #(
    parameter int ALUOP_W        = 5,
    parameter int LOAD_STALL_CYC = 1,
    parameter int FLUSH_CYC      = 2,
    parameter int CNT_W          = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [4:0]         rd,
    input  logic               mispredict,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               ALUSrc,
    output logic               PCSrcCont,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic               IsStall,
    output logic               illegal,
    output logic               hold
);
    typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (ALUOP_W < 5 || LOAD_STALL_CYC < 1 || FLUSH_CYC < 1 ||
        LOAD_STALL_CYC > CNT_MAX || FLUSH_CYC > CNT_MAX) begin : g_param_check
        $error("ctrl_unit_pipelined: illegal parameter set");
    end

    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;
    logic [4:0]       r_last_rd;
    logic [4:0]       w_op;
    logic             w_legal, w_src, w_pc, w_mw, w_mr, w_m2r, w_rw;
    logic             w_uses_rs2, w_is_lw, w_hazard, w_issue, w_dec;

    always_comb begin
        w_op    = 5'h1F;
        w_legal = 1'b0;
        w_src   = 1'b0;
        w_pc    = 1'b0;
        w_mw    = 1'b0;
        w_mr    = 1'b0;
        w_m2r   = 1'b0;
        w_rw    = 1'b0;
        case (opcode)
            7'b0110011: begin
                w_legal = 1'b1;
                w_rw    = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: w_op = 5'd0;
                    {7'h20, 3'b000}: w_op = 5'd1;
                    {7'h00, 3'b111}: w_op = 5'd2;
                    {7'h00, 3'b110}: w_op = 5'd3;
                    {7'h00, 3'b100}: w_op = 5'd5;
                    {7'h00, 3'b001}: w_op = 5'd6;
                    {7'h00, 3'b101}: w_op = 5'd7;
                    {7'h20, 3'b101}: w_op = 5'd8;
                    {7'h00, 3'b010}: w_op = 5'd9;
                    default:         w_legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                w_legal = 1'b1;
                w_src   = 1'b1;
                w_rw    = 1'b1;
                case (funct3)
                    3'b000:  w_op = 5'd0;
                    3'b111:  w_op = 5'd2;
                    3'b110:  w_op = 5'd3;
                    3'b100:  w_op = 5'd5;
                    3'b010:  w_op = 5'd9;
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0000011: begin
                w_legal = (funct3 == 3'b010);
                w_op    = 5'd0;
                w_src   = 1'b1;
                w_mr    = 1'b1;
                w_m2r   = 1'b1;
                w_rw    = 1'b1;
            end
            7'b0100011: begin
                w_legal = (funct3 == 3'b010);
                w_op    = 5'd0;
                w_src   = 1'b1;
                w_mw    = 1'b1;
            end
            7'b1100011: begin
                w_legal = 1'b1;
                w_pc    = 1'b1;
                case (funct3)
                    3'b000:  w_op = 5'd4;
                    3'b001:  w_op = 5'd10;
                    3'b100:  w_op = 5'd11;
                    3'b101:  w_op = 5'd12;
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // rs2 is only a real source operand for R-type, stores and branches
    assign w_uses_rs2 = (opcode == 7'b0110011) || (opcode == 7'b0100011) || (opcode == 7'b1100011);
    assign w_is_lw    = (opcode == 7'b0000011);
    assign w_hazard   = (r_state == RUN) && instr_valid && (r_last_rd != 5'd0) &&
                        ((rs1 == r_last_rd) || (w_uses_rs2 && (rs2 == r_last_rd)));
    assign w_dec      = w_issue && instr_valid && w_legal;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_issue      = 1'b0;
        hold         = 1'b0;
        if (mispredict) begin
            w_next_state = (FLUSH_CYC > 1) ? FLUSH : RUN;
            w_next_cnt   = CNT_W'(FLUSH_CYC - 1);
        end else begin
            case (r_state)
                RUN: begin
                    if (w_hazard) begin
                        hold         = 1'b1;
                        w_next_state = (LOAD_STALL_CYC > 1) ? LSTALL : RUN;
                        w_next_cnt   = CNT_W'(LOAD_STALL_CYC - 1);
                    end else begin
                        w_issue = 1'b1;
                    end
                end
                LSTALL: begin
                    hold         = 1'b1;
                    w_next_cnt   = r_cnt - CNT_W'(1);
                    w_next_state = (r_cnt == CNT_W'(1)) ? RUN : LSTALL;
                end
                FLUSH: begin
                    w_next_cnt   = r_cnt - CNT_W'(1);
                    w_next_state = (r_cnt == CNT_W'(1)) ? RUN : FLUSH;
                end
                default: w_next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_last_rd <= '0;
            ALUOp     <= '1;
            {ALUSrc, PCSrcCont, MemWrite, MemRead, MemToReg, RegWrite} <= '0;
            IsStall   <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_last_rd <= (w_dec && w_is_lw) ? rd : 5'd0;
            ALUOp     <= w_dec ? ALUOP_W'(w_op) : '1;
            {ALUSrc, PCSrcCont, MemWrite, MemRead, MemToReg, RegWrite} <=
                w_dec ? {w_src, w_pc, w_mw, w_mr, w_m2r, w_rw} : 6'd0;
            IsStall   <= !w_issue;
            illegal   <= w_issue && instr_valid && !w_legal;
        end
    end
endmodule
